mult_share_scheduler: RTL
=========================

Name: mult_share_scheduler

Overview:
- Shares one pipelined WIDTH x WIDTH multiplier among NREQ requesters using round-robin arbitration.
- Applies operand isolation: multiplier inputs stay stable whenever no operation is accepted.
- Sequences a low-power idle mode. After IDLE_CYCLES idle cycles it drops the multiplier clock-enable, then wakes on demand.
- Sits between requesting datapath units and the shared arithmetic resource in power-aware compute clusters.

Parameters:
- WIDTH, 16, operand width in bits.
- NREQ, 4, number of requesters (2..8).
- LAT, 2, multiplier pipeline depth in cycles from accept to response (1..4).
- IDLE_CYCLES, 8, consecutive idle cycles before sleep; 0 disables sleep.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept; a handshake occurs when valid and ready are both high.
- req_a  in  NREQ*WIDTH  packed operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing.
- rsp_valid  out  1  product valid, one-cycle pulse.
- rsp_id  out  $clog2(NREQ) (min 1)  index of the requester that owns rsp_product.
- rsp_product  out  2*WIDTH  unsigned product.
- mult_clk_en  out  1  clock-gate enable for the multiplier pipeline.
- busy  out  1  high when any operation is in flight or state is not SLEEP/ACTIVE-idle.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is SLEEP.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_product = 0.
  - mult_clk_en = 0, busy = 0.
  - RR pointer = 0, idle counter = 0.
  - All pipeline valid bits are cleared.
- FSM states are SLEEP, WAKE, ACTIVE.
  - SLEEP: mult_clk_en = 0 and req_ready = 0. Any req_valid bit high moves to WAKE on the next edge.
  - WAKE: lasts exactly one cycle. mult_clk_en = 1 and req_ready = 0. Always moves to ACTIVE next.
  - ACTIVE: mult_clk_en = 1 and arbitration is enabled.
- Sleep entry from ACTIVE:
  - The idle counter increments on each cycle with no req_valid and an empty pipeline. Any other cycle clears it.
  - When the counter reaches IDLE_CYCLES-1 on an idle cycle, the next state is SLEEP and the counter clears.
  - With IDLE_CYCLES = 0, the FSM never enters SLEEP.
- Arbitration (ACTIVE only):
  - req_ready is combinational and one-hot or zero.
  - It grants the first requester with req_valid set, searching upward from the RR pointer with wrap-around.
  - On a handshake, the pointer becomes (granted index + 1) mod NREQ. Otherwise the pointer holds.
  - At most one operation is accepted per cycle.
- Operand isolation:
  - The stage-0 operand registers load only on a handshake and otherwise hold their value.
  - Non-granted req_a/req_b never reach the multiplier.
  - Pipeline data registers update only where their stage valid bit is set.
- Latency:
  - A handshake at cycle T gives rsp_valid = 1 during cycle T+LAT.
  - rsp_id is the granted index and rsp_product = a*b, full 2*WIDTH bits with no truncation.
  - Throughput is one result per cycle.
- Hold behaviour: when rsp_valid = 0, rsp_product and rsp_id hold their last values to avoid toggling.
- Responses have no backpressure; requesters must accept rsp_valid.
- Ordering: responses return in accept order.
- Pipeline and state interaction: the FSM cannot leave ACTIVE while any pipeline stage is valid.
- Simultaneous events:
  - A request on the final idle-count cycle cancels the sleep transition.
  - A req_valid deasserted during WAKE still completes WAKE, then ACTIVE counts idle normally.
- rst asserted mid-operation:
  - All in-flight operations are discarded.
  - No rsp_valid is generated for them.
  - Outputs return to their reset values on the next edge.
- busy = (state == WAKE) or any pipeline valid bit set.

Test Plan:
- Reset, then req_valid[2] = 1 with a = 3, b = 5 from cycle 0 -> WAKE in cycle 1, req_ready[2] = 1 in cycle 2, rsp_valid in cycle 4 with rsp_id = 2 and rsp_product = 15.
- ACTIVE with all four requesters held valid for 8 cycles -> grants are 0,1,2,3,0,1,2,3 and 8 back-to-back rsp_valid pulses in the same order.
- a = 0xFFFF, b = 0xFFFF -> rsp_product = 0xFFFE0001.
- Idle after the last response -> mult_clk_en falls exactly IDLE_CYCLES cycles after the pipeline empties; req_ready stays 0 in SLEEP. A request on that final idle cycle keeps mult_clk_en = 1.
- Toggle req_a/req_b of non-requesting ports every cycle while idle -> operand registers and rsp_product show zero transitions.
- Assert rst for 1 cycle with 2 operations in flight -> no rsp_valid follows, and outputs read 0 in the next cycle.

Source files
------------

// File: rtl/mult_share_scheduler.sv
// mult_share_scheduler: round-robin sharing of one pipelined multiplier
// with operand isolation and an idle-driven sleep/wake sequencer.
module mult_share_scheduler #(
   parameter int WIDTH       = 16,
   parameter int NREQ        = 4,
   parameter int LAT         = 2,
   parameter int IDLE_CYCLES = 8,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product,
   output logic                  mult_clk_en,
   output logic                  busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam int CLAST = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
   localparam bit SLEEP_EN = (IDLE_CYCLES > 0);
   localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);
   localparam logic [IDW-1:0] IDX_LAST = IDW'(NREQ - 1);

   typedef enum logic [1:0] {
      S_SLEEP  = 2'd0,
      S_WAKE   = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic            arb_en;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW:0]    cand;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
   logic            hs;

   logic [CW-1:0]   idle_cnt;
   logic            idle;
   logic            idle_last;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [IDW-1:0]   op_id;
   logic [LAT-1:0]   vld;
   logic [PW-1:0]    mul;

   // first valid requester at or above the pointer, wrapping
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[IDW-1:0];
         end
      end
      if (gnt_any) gnt = NREQ'(1) << gnt_idx;
   end

   assign req_ready = arb_en ? gnt : '0;
   assign hs        = arb_en & gnt_any;

   // pointer moves past the winner only on an accepted operation
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (hs) begin
         if (gnt_idx == IDX_LAST) rr_ptr <= '0;
         else rr_ptr <= gnt_idx + IDW'(1);
      end
   end

   assign idle      = ~|req_valid & ~|vld;
   assign idle_last = idle & (idle_cnt == CW'(CLAST));

   // count consecutive idle ACTIVE cycles toward sleep
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (state != S_ACTIVE || !idle
                   || !SLEEP_EN || idle_last) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + CW'(1);
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_SLEEP;
      else state <= state_nxt;
   end

   // next state: a pipeline op keeps idle low, so ACTIVE holds
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_SLEEP:  if (|req_valid) state_nxt = S_WAKE;
         S_WAKE:   state_nxt = S_ACTIVE;
         S_ACTIVE: if (SLEEP_EN && idle_last) state_nxt = S_SLEEP;
         default:  state_nxt = S_SLEEP;
      endcase
   end

   // state outputs: clock enable and arbitration enable
   always_comb begin
      mult_clk_en = 1'b0;
      arb_en      = 1'b0;
      unique case (1'b1)
         (state == S_WAKE): begin
            mult_clk_en = 1'b1;
         end
         (state == S_ACTIVE): begin
            mult_clk_en = 1'b1;
            arb_en      = 1'b1;
         end
         default: ;
      endcase
   end

   // isolated operand stage: loads only on a handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a  <= '0;
         op_b  <= '0;
         op_id <= '0;
      end else if (hs) begin
         op_a  <= req_a[int'(gnt_idx) * WIDTH +: WIDTH];
         op_b  <= req_b[int'(gnt_idx) * WIDTH +: WIDTH];
         op_id <= gnt_idx;
      end
   end

   // stage valid chain; the last bit is the response strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld[0] <= hs;
         for (int k = 1; k < LAT; k++) vld[k] <= vld[k-1];
      end
   end

   assign mul = PW'(op_a) * PW'(op_b);

   if (LAT == 1) begin : g_lat1
      assign rsp_product = mul;
      assign rsp_id      = op_id;
   end else begin : g_pipe
      logic [PW-1:0]  pd  [LAT-1];
      logic [IDW-1:0] pid [LAT-1];

      // product stages advance only behind a valid upstream stage
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j < LAT - 1; j++) begin
               pd[j]  <= '0;
               pid[j] <= '0;
            end
         end else begin
            if (vld[0]) begin
               pd[0]  <= mul;
               pid[0] <= op_id;
            end
            for (int j = 1; j < LAT - 1; j++) begin
               if (vld[j]) begin
                  pd[j]  <= pd[j-1];
                  pid[j] <= pid[j-1];
               end
            end
         end
      end

      assign rsp_product = pd[LAT-2];
      assign rsp_id      = pid[LAT-2];
   end

   assign rsp_valid = vld[LAT-1];
   assign busy      = (state == S_WAKE) | (|vld);

endmodule
